// File: rtl/env_adsr.sv
// env_adsr: per-voice ADSR amplitude envelope.
// Scales each offset-binary sample about midscale by the current envelope
// level and advances the envelope once per sample tick under gate control.
// Optional build macro ENV_ADSR_EXP_RELEASE_EN selects an exponential release
// step (level >> release_rate[3:0], minimum 1) instead of the linear one.
module env_adsr #(
   parameter int SAMPLE_W = 16,
   parameter int ENV_W    = 12,
   parameter int RATE_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                gate,
   input  logic [RATE_W-1:0]   attack_rate,
   input  logic [RATE_W-1:0]   decay_rate,
   input  logic [ENV_W-1:0]    sustain_level,
   input  logic [RATE_W-1:0]   release_rate,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_out_valid,
   output logic [ENV_W-1:0]    env_level,
   output logic [2:0]          env_state
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } state_t;

   localparam int                 PAD      = ENV_W + 1 - RATE_W;
   localparam logic [ENV_W-1:0]   ENV_FULL = '1;
   localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

   state_t            state, state_nxt;
   logic [ENV_W-1:0]  level, level_nxt;
   logic              gate_q;
   logic              trig;

   logic [ENV_W:0]    att_sum;
   logic [ENV_W-1:0]  att_level;
   logic [ENV_W:0]    dec_diff;
   logic [ENV_W:0]    rel_step;
   logic [ENV_W:0]    rel_diff;

   logic signed [SAMPLE_W-1:0]       s_signed;
   logic signed [SAMPLE_W+ENV_W-1:0] prod;
   logic [SAMPLE_W-1:0]              scaled;
   logic [ENV_W-1:0]                 prod_frac_unused;

   // Gate edge detector: a rising edge arms the trigger, the next tick consumes it.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_q <= 1'b0;
         trig   <= 1'b0;
      end else begin
         gate_q <= gate;
         trig   <= (gate & ~gate_q) | (trig & ~sample_valid);
      end
   end

   // Envelope step arithmetic, one extra bit so nothing wraps.
   always_comb begin
      att_sum   = {1'b0, level} + {{PAD{1'b0}}, attack_rate};
      att_level = att_sum[ENV_W] ? ENV_FULL : att_sum[ENV_W-1:0];
      dec_diff  = {1'b0, level} - {{PAD{1'b0}}, decay_rate};
`ifdef ENV_ADSR_EXP_RELEASE_EN
      rel_step  = ((level >> release_rate[3:0]) == '0) ?
                  (ENV_W+1)'(1) : {1'b0, level >> release_rate[3:0]};
`else
      rel_step  = {{PAD{1'b0}}, release_rate};
`endif
      rel_diff  = {1'b0, level} - rel_step;
   end

   // Next-state and next-level logic; only a sample tick moves the envelope.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      if (sample_valid) begin
         if (trig) begin
            // Retrigger continues from the current level rather than from 0.
            level_nxt = att_level;
            state_nxt = (att_level == ENV_FULL) ? ST_DECAY : ST_ATTACK;
         end else if (!gate && (state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
            // Level holds this tick; the release step starts on the next one.
            state_nxt = ST_RELEASE;
         end else begin
            case (state)
               ST_IDLE: level_nxt = '0;
               ST_ATTACK: begin
                  level_nxt = att_level;
                  if (att_level == ENV_FULL) state_nxt = ST_DECAY;
               end
               ST_DECAY: begin
                  if (level <= sustain_level || dec_diff[ENV_W] ||
                      dec_diff[ENV_W-1:0] <= sustain_level) begin
                     level_nxt = sustain_level;
                     state_nxt = ST_SUSTAIN;
                  end else begin
                     level_nxt = dec_diff[ENV_W-1:0];
                  end
               end
               ST_SUSTAIN: level_nxt = sustain_level;
               ST_RELEASE: begin
                  if (rel_diff[ENV_W] || rel_diff[ENV_W-1:0] == '0) begin
                     level_nxt = '0;
                     state_nxt = ST_IDLE;
                  end else begin
                     level_nxt = rel_diff[ENV_W-1:0];
                  end
               end
               default: begin
                  level_nxt = '0;
                  state_nxt = ST_IDLE;
               end
            endcase
         end
      end
   end

   // Envelope state and level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         level <= '0;
      end else begin
         state <= state_nxt;
         level <= level_nxt;
      end
   end

   // Scale the sample about midscale using the pre-update level.
   always_comb begin
      s_signed = {~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0]};
      prod     = s_signed * $signed({1'b0, level});
      {scaled, prod_frac_unused} = {~prod[SAMPLE_W+ENV_W-1], prod[SAMPLE_W+ENV_W-2:0]};
   end

   // Output register: updated and flagged on the same edge that takes the tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_out       <= MIDSCALE;
         sample_out_valid <= 1'b0;
      end else begin
         sample_out_valid <= sample_valid;
         if (sample_valid) sample_out <= scaled;
      end
   end

`ifdef ENV_ADSR_EXP_RELEASE_EN
   logic [RATE_W-5:0] release_hi_unused;
   assign release_hi_unused = release_rate[RATE_W-1:4];
`endif

   assign env_level = level;
   assign env_state = state;

endmodule

// File: tb/tb_env_adsr.sv
// tb_env_adsr: directed self-checking bench for env_adsr.
// A scaling table is replayed in SUSTAIN; hand-written sequences cover
// attack/decay, release, retrigger, short gate, back-to-back ticks and reset.
module tb_env_adsr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        gate;
   logic [7:0]  attack_rate, decay_rate, release_rate;
   logic [11:0] sustain_level;
   logic [15:0] sample_out;
   logic        sample_out_valid;
   logic [11:0] env_level;
   logic [2:0]  env_state;

   int checks = 0;
   int errors = 0;

   logic [15:0] out1;
   logic        v1, v2;

   typedef struct {
      logic [11:0] sus;
      logic [15:0] in;
      logic [15:0] exp_out;
   } vec_t;

   vec_t vecs[8];

   env_adsr dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sample_in        (sample_in),
      .sample_valid     (sample_valid),
      .gate             (gate),
      .attack_rate      (attack_rate),
      .decay_rate       (decay_rate),
      .sustain_level    (sustain_level),
      .release_rate     (release_rate),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .env_level        (env_level),
      .env_state        (env_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One sample tick from a negedge; returns 4 clocks later on a negedge.
   task automatic tick();
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      out1 = sample_out;
      v1   = sample_out_valid;
      @(negedge clk);
      v2 = sample_out_valid;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      // Expected outputs: s = in ^ 0x8000 (signed), (s * sus) >>> 12, MSB flipped.
      vecs[0] = '{12'hFFF, 16'hFFFF, 16'hFFF7}; // 32767*4095>>12 = 32759
      vecs[1] = '{12'hFFF, 16'h0000, 16'h0008}; // -32768*4095>>12 = -32760
      vecs[2] = '{12'h800, 16'h0000, 16'h4000};
      vecs[3] = '{12'h800, 16'hFFFF, 16'hBFFF}; // 16383.5 floors to 16383
      vecs[4] = '{12'h400, 16'hC000, 16'h9000};
      vecs[5] = '{12'h800, 16'h7FFF, 16'h7FFF}; // -1*2048>>>12 = -1
      vecs[6] = '{12'h000, 16'h1234, 16'h8000};
      vecs[7] = '{12'h800, 16'h8000, 16'h8000};

      rst_n         = 1'b0;
      sample_in     = 16'h8000;
      sample_valid  = 1'b0;
      gate          = 1'b0;
      attack_rate   = 8'd64;
      decay_rate    = 8'd16;
      release_rate  = 8'd32;
      sustain_level = 12'h800;
      #23;
      check("reset_state", 32'(env_state), 32'd0);
      check("reset_level", 32'(env_level), 32'h0);
      check("reset_out",   32'(sample_out), 32'h8000);
      check("reset_valid", 32'(sample_out_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Attack to full scale, decay to sustain.
      gate = 1'b1;
      @(negedge clk);
      tick();
      check("attack_first_level", 32'(env_level), 32'h040);
      check("attack_first_state", 32'(env_state), 32'd1);
      ticks(62);
      check("attack_63_level", 32'(env_level), 32'hFC0);
      check("attack_63_state", 32'(env_state), 32'd1);
      tick();
      check("attack_sat_level", 32'(env_level), 32'hFFF);
      check("attack_sat_state", 32'(env_state), 32'd2);
      ticks(127);
      check("decay_127_level", 32'(env_level), 32'h80F);
      check("decay_127_state", 32'(env_state), 32'd2);
      tick();
      check("decay_end_level", 32'(env_level), 32'h800);
      check("decay_end_state", 32'(env_state), 32'd3);

      // Scaling table in SUSTAIN: first tick loads the level, second scales.
      for (int i = 0; i < 8; i++) begin
         sustain_level = vecs[i].sus;
         sample_in     = 16'h8000;
         tick();
         sample_in = vecs[i].in;
         tick();
         check($sformatf("scale_out[%0d]", i), 32'(out1), 32'(vecs[i].exp_out));
         check($sformatf("scale_level[%0d]", i), 32'(env_level), 32'(vecs[i].sus));
         if (i == 0) begin
            check("valid_pulse_hi", 32'(v1), 32'h1);
            check("valid_pulse_lo", 32'(v2), 32'h0);
         end
      end
      check("sustain_state", 32'(env_state), 32'd3);

      // Back-to-back ticks at level 0x800.
      sample_valid = 1'b1;
      sample_in    = 16'h0000;
      @(negedge clk);
      sample_in = 16'hFFFF;
      check("b2b_out0", 32'(sample_out), 32'h4000);
      check("b2b_valid0", 32'(sample_out_valid), 32'h1);
      @(negedge clk);
      sample_valid = 1'b0;
      check("b2b_out1", 32'(sample_out), 32'hBFFF);
      check("b2b_valid1", 32'(sample_out_valid), 32'h1);
      @(negedge clk);
      check("b2b_valid_end", 32'(sample_out_valid), 32'h0);
      check("b2b_out_hold", 32'(sample_out), 32'hBFFF);
      sample_in = 16'h8000;

`ifndef ENV_ADSR_EXP_RELEASE_EN
      // Linear release from 0x800 at 32 per tick.
      gate = 1'b0;
      tick();
      check("release_enter_state", 32'(env_state), 32'd4);
      check("release_enter_level", 32'(env_level), 32'h800);
      ticks(63);
      check("release_63_level", 32'(env_level), 32'h020);
      check("release_63_state", 32'(env_state), 32'd4);
      tick();
      check("release_end_level", 32'(env_level), 32'h000);
      check("release_end_state", 32'(env_state), 32'd0);
`else
      // Exponential release: 0x100 - (0x100 >> 4) = 0x0F0.
      sustain_level = 12'h100;
      tick();
      gate         = 1'b0;
      release_rate = 8'd4;
      tick();
      check("exp_enter_state", 32'(env_state), 32'd4);
      check("exp_enter_level", 32'(env_level), 32'h100);
      tick();
      check("exp_step_level", 32'(env_level), 32'h0F0);
      release_rate = 8'd0;
      tick();
      check("exp_end_level", 32'(env_level), 32'h000);
      check("exp_end_state", 32'(env_state), 32'd0);
`endif

      // Retrigger from a RELEASE level of 0x400.
      gate = 1'b1;
      @(negedge clk);
      ticks(16);
      check("retrig_build_level", 32'(env_level), 32'h400);
      check("retrig_build_state", 32'(env_state), 32'd1);
      gate = 1'b0;
      tick();
      check("retrig_rel_state", 32'(env_state), 32'd4);
      check("retrig_rel_level", 32'(env_level), 32'h400);
      gate = 1'b1;
      @(negedge clk);
      tick();
      check("retrig_state", 32'(env_state), 32'd1);
      check("retrig_level", 32'(env_level), 32'h440);

      // One-clock gate pulse between ticks.
      gate = 1'b0;
      tick();
      check("short_pre_state", 32'(env_state), 32'd4);
      gate = 1'b1;
      @(negedge clk);
      gate = 1'b0;
      @(negedge clk);
      tick();
      check("short_attack_state", 32'(env_state), 32'd1);
      check("short_attack_level", 32'(env_level), 32'h480);
      tick();
      check("short_release_state", 32'(env_state), 32'd4);
      check("short_release_level", 32'(env_level), 32'h480);
`ifndef ENV_ADSR_EXP_RELEASE_EN
      tick();
      check("short_release_step", 32'(env_level), 32'h460);
`endif

      // Asynchronous reset in the middle of ATTACK.
      gate      = 1'b1;
      sample_in = 16'hFFFF;
      @(negedge clk);
      tick();
      check("midop_state", 32'(env_state), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midop_rst_state", 32'(env_state), 32'd0);
      check("midop_rst_level", 32'(env_level), 32'h0);
      check("midop_rst_out",   32'(sample_out), 32'h8000);
      check("midop_rst_valid", 32'(sample_out_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
